seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
Time-shares the single 8-digit seven-segment display between NUM_REQ independent requesters. Each requester offers a 32-bit hex value. The block grants the display round-robin with a minimum dwell time and an optional blank gap between owners. Its val_out feeds the display controller's 32-bit value input directly; grant/owner outputs drive status LEDs.

Parameters:
NUM_REQ, 4, number of requesters (legal range 2..16)
DWELL_CYCLES, 50_000_000, clock cycles an owner holds the display before re-arbitration (>=2)
GAP_CYCLES, 5_000_000, blank cycles between different owners (0 = no gap state)
BLANK_VAL, 32'h0000_0000, value driven on val_out when no owner

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
req_in  input  NUM_REQ  per-requester display request, level
val_in  input  32*NUM_REQ  requester i value in bits [32*i+31:32*i]
pin_in  input  1  hold current owner indefinitely while high
grant_out  output  NUM_REQ  one-hot current owner, all zero when none
owner_out  output  max(1,$clog2(NUM_REQ))  index of current owner, holds last owner when none
val_out  output  32  value to display controller
active_out  output  1  high in SHOW
switch_out  output  1  one-cycle pulse on every new grant

Behaviour:
- Single clock; reset is asynchronous, active-high, on clk_in/rst_in.
- Reset values: state IDLE, grant_out 0, owner_out 0, val_out BLANK_VAL, active_out 0, switch_out 0, rr_ptr 0, counter 0.
- All outputs registered. In SHOW, val_out <= val_in slice of the owner every cycle. Requester value changes appear on val_out 1 cycle later.
- Arbitration (ARB event):
  - Pick the first i with req_in[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Winner takes effect next cycle: grant_out one-hot, owner_out=i, switch_out=1 for that single cycle, active_out=1, counter=0.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - val_out of the grant cycle = val_in[i] sampled at the ARB cycle.
- States:
  - IDLE: ARB every cycle. No request -> stay; grant_out 0, val_out BLANK_VAL.
  - SHOW, each cycle, in priority order:
    - (1) Owner req low -> end tenure.
    - (2) pin_in high -> stay, counter frozen.
    - (3) counter==DWELL_CYCLES-1 -> dwell expiry.
    - (4) else counter+1.
  - Dwell expiry:
    - If any other requester is high -> end tenure.
    - Otherwise counter <= 0, stay, no switch_out.
  - End tenure:
    - GAP_CYCLES>0 -> GAP, counter 0.
    - GAP_CYCLES==0 -> ARB in the same cycle, excluding nothing.
    - Because rr_ptr has advanced, a different requester wins if present. A re-grant to the same owner pulses switch_out.
  - GAP: grant_out 0, active_out 0, val_out BLANK_VAL. When counter==GAP_CYCLES-1 -> ARB. No winner -> IDLE.
- Boundary conditions:
  - pin_in has no effect in IDLE/GAP.
  - Owner drop overrides pin_in.
  - Owner drop and dwell expiry in the same cycle: treated as owner drop.
  - Requests arriving during GAP are considered at the GAP-end ARB only.
  - Counter is 32 bits; no wrap within legal parameters.
  - rst_in asserted mid-SHOW or mid-GAP: outputs return to reset values immediately (async), without waiting for a clock edge.
  - val_in of non-owners is ignored.

Test Plan:
Bench parameters: NUM_REQ=4, DWELL_CYCLES=8, GAP_CYCLES=2, BLANK_VAL=0.
- Single requester: req_in=4'b0100, val_in[2]=32'hDEAD_BEEF from IDLE -> next cycle grant_out=0100, owner_out=2, switch_out pulse, val_out=DEADBEEF. Holds past 8 cycles with no further switch_out.
- Round-robin: req_in=4'b1011 constant from reset -> owners 0,1,3,0,... Each tenure 8 cycles of active_out, then 2 cycles of val_out=0, grant_out=0.
- Owner drop: owner 1 drops req at SHOW counter 3 -> next cycle GAP, two cycles later owner 3 granted.
- Pin: pin_in=1 while owner 0 shows and req_in=4'b1111 -> no switch for 40 cycles. Release pin -> counter resumes from frozen value and switches after remaining dwell.
- Live value update: owner 2 changes val_in from 32'h1 to 32'h2 at cycle t -> val_out=2 at t+1.
- Async reset mid-SHOW: rst_in pulsed between clock edges -> grant_out=0, val_out=0, active_out=0 before the next edge. After release with req_in=4'b0010 -> owner 1 granted.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-sharing of one 8-digit display between requesters
module seg_display_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int GAP_CYCLES = 5_000_000,
  parameter logic [31:0] BLANK_VAL = 32'h0000_0000,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      req_in,
  input  logic [32*NUM_REQ-1:0]   val_in,
  input  logic                    pin_in,
  output logic [NUM_REQ-1:0]      grant_out,
  output logic [OW-1:0]           owner_out,
  output logic [31:0]             val_out,
  output logic                    active_out,
  output logic                    switch_out
);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, win, win_lo, win_hi;
  logic [31:0] val_q, val_d, cnt_q, cnt_d;
  logic active_q, active_d, switch_q, switch_d;
  logic found, hi, arb, end_t;
  logic [31:0] vals [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_v
    assign vals[g] = val_in[32*g +: 32];
  end
  // lowest requester at or above rr_q wins, else lowest overall (wrap-around)
  always_comb begin
    found = 1'b0;
    hi = 1'b0;
    win_lo = '0;
    win_hi = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_in[i]) begin
        found = 1'b1;
        win_lo = OW'(i);
        if (i >= int'(rr_q)) begin
          hi = 1'b1;
          win_hi = OW'(i);
        end
      end
    win = hi ? win_hi : win_lo;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d = rr_q;
    val_d = val_q;
    cnt_d = cnt_q;
    active_d = active_q;
    switch_d = 1'b0;
    arb = 1'b0;
    end_t = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      SHOW: begin
        val_d = vals[owner_q];
        if (!req_in[owner_q]) end_t = 1'b1;
        else if (pin_in) cnt_d = cnt_q;
        else if (cnt_q == DWELL_LAST) begin
          if (|(req_in & ~grant_q)) end_t = 1'b1;
          else cnt_d = '0;
        end else cnt_d = cnt_q + 32'd1;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) arb = 1'b1;
        else cnt_d = cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
    if (end_t) begin
      if (GAP_CYCLES > 0) begin
        state_d = GAP;
        cnt_d = '0;
        grant_d = '0;
        active_d = 1'b0;
        val_d = BLANK_VAL;
      end else arb = 1'b1;
    end
    if (arb) begin
      if (found) begin
        state_d = SHOW;
        grant_d = NUM_REQ'(1) << win;
        owner_d = win;
        rr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        val_d = vals[win];
        cnt_d = '0;
        active_d = 1'b1;
        switch_d = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        val_d = BLANK_VAL;
        active_d = 1'b0;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q <= '0;
      val_q <= BLANK_VAL;
      cnt_q <= '0;
      active_q <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      switch_q <= switch_d;
    end
  end
  assign grant_out = grant_q;
  assign owner_out = owner_q;
  assign val_out = val_q;
  assign active_out = active_q;
  assign switch_out = switch_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed stimulus against a tenure/gap behavioural model
module tb_seg_display_scheduler;
  localparam int N = 4, DW = 8, GP = 2;
  logic clk = 1'b0, rst = 1'b1, pin = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] v [4];
  logic [127:0] val_in;
  logic [3:0] grant;
  logic [1:0] owner;
  logic [31:0] val;
  logic active, sw;
  int vectors = 0, errors = 0;
  int m_owner, m_last, m_rr, m_held, m_gap;
  logic [31:0] m_val;
  bit m_sw, m_arb_now, m_drop;
  assign val_in = {v[3], v[2], v[1], v[0]};
  always #5 clk = ~clk;
  seg_display_scheduler #(.NUM_REQ(N), .DWELL_CYCLES(DW), .GAP_CYCLES(GP), .BLANK_VAL(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .val_in(val_in), .pin_in(pin),
    .grant_out(grant), .owner_out(owner), .val_out(val), .active_out(active), .switch_out(sw)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_owner = -1; m_last = 0; m_rr = 0; m_held = 0; m_gap = 0; m_val = 0; m_sw = 0;
  endfunction
  task automatic m_arb();
    m_owner = -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (m_owner < 0 && req[c]) m_owner = c;
    end
    if (m_owner >= 0) begin
      m_last = m_owner; m_rr = (m_owner + 1) % N; m_held = 0; m_sw = 1;
    end
  endtask
  // owner = -1 means nobody holds the display; m_gap counts blank cycles left
  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      m_sw = 0; m_arb_now = 0; m_drop = 0;
      if (m_gap > 0) begin m_gap--; m_arb_now = (m_gap == 0); end
      else if (m_owner < 0) m_arb_now = 1;
      else if (!req[m_owner]) m_drop = 1;
      else if (pin) m_held = m_held;
      else if (m_held == DW - 1) begin
        if ((req & ~(4'b0001 << m_owner)) != 0) m_drop = 1;
        else m_held = 0;
      end else m_held++;
      if (m_drop) begin m_owner = -1; m_gap = GP; end
      if (m_arb_now) m_arb();
      m_val = (m_owner >= 0) ? v[m_owner] : 32'h0;
    end
  end
  always @(negedge clk) begin
    check("grant", 32'(grant), m_owner >= 0 ? (32'd1 << m_owner) : 32'd0);
    check("owner", 32'(owner), 32'(m_last));
    check("val", val, m_val);
    check("active", 32'(active), 32'(m_owner >= 0));
    check("switch", 32'(sw), 32'(m_sw));
  end
  task automatic reset_to(logic [3:0] r);
    rst = 1'b1; req = r; pin = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    m_reset();
    v = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0); check("rst_owner", 32'(owner), 0);
    check("rst_val", val, 0); check("rst_active", 32'(active), 0); check("rst_sw", 32'(sw), 0);
    req = 4'b0100; v[2] = 32'hDEAD_BEEF; rst = 1'b0;
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'b0100); check("t1_owner", 32'(owner), 2);
    check("t1_sw", 32'(sw), 1); check("t1_val", val, 32'hDEAD_BEEF);
    repeat (12) @(negedge clk);
    check("t1_hold_sw", 32'(sw), 0); check("t1_hold_grant", 32'(grant), 32'b0100);
    check("t1_hold_val", val, 32'hDEAD_BEEF);
    v = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
    reset_to(4'b1011);
    @(negedge clk);
    check("rr_o0", 32'(owner), 0); check("rr_o0_sw", 32'(sw), 1); check("rr_o0_val", val, 32'hA0A0_A0A0);
    repeat (8) @(negedge clk);
    check("rr_gap_grant", 32'(grant), 0); check("rr_gap_val", val, 0); check("rr_gap_act", 32'(active), 0);
    repeat (2) @(negedge clk);
    check("rr_o1", 32'(owner), 1); check("rr_o1_grant", 32'(grant), 32'b0010); check("rr_o1_sw", 32'(sw), 1);
    repeat (3) @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    check("drop_gap", 32'(active), 0); check("drop_grant", 32'(grant), 0);
    repeat (2) @(negedge clk);
    check("drop_o3", 32'(owner), 3); check("drop_o3_sw", 32'(sw), 1); check("drop_o3_val", val, 32'hD3D3_D3D3);
    reset_to(4'b1111);
    @(negedge clk);
    check("pin_o0", 32'(owner), 0);
    repeat (3) @(negedge clk);
    pin = 1'b1;
    repeat (40) @(negedge clk);
    check("pin_hold", 32'(owner), 0); check("pin_active", 32'(active), 1); check("pin_sw", 32'(sw), 0);
    pin = 1'b0;
    repeat (4) @(negedge clk);
    check("pin_rem", 32'(active), 1);
    @(negedge clk);
    check("pin_gap", 32'(active), 0);
    repeat (2) @(negedge clk);
    check("pin_o1", 32'(owner), 1); check("pin_o1_sw", 32'(sw), 1);
    v[2] = 32'h1;
    reset_to(4'b0100);
    @(negedge clk);
    check("live_v1", val, 32'h1);
    repeat (2) @(negedge clk);
    v[2] = 32'h2;
    @(negedge clk);
    check("live_v2", val, 32'h2);
    #2 rst = 1'b1;
    #1;
    check("async_grant", 32'(grant), 0); check("async_val", val, 0); check("async_active", 32'(active), 0);
    req = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_o1", 32'(owner), 1); check("post_rst_grant", 32'(grant), 32'b0010);
    check("post_rst_val", val, 32'hB1B1_B1B1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
